// File: rtl/nibble_rx_pkg.sv
// Shared types and defaults for the nibble receiver.
// Holds the byte-phase enum, the FIFO depth default and the parity helper.
package nibble_rx_pkg;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_t;

    localparam int DEPTH_DEF = 4;

    // True when the 9-bit word {byte, parity} has an odd number of ones.
    function automatic logic parity_odd(input logic [7:0] byte_dat, input logic par);
        return ^{byte_dat, par};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Latency: a push is visible at dout the cycle after its edge; pop is combinational on the head.
// Backpressure: a push while full is accepted only if a pop happens on the same edge.
module sync_fifo
    import nibble_rx_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_q;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem[rd_ptr];

    // When full, the write slot equals the head slot; overwriting it is safe
    // only because the head leaves on the same edge.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/nibble_rx.sv
// Toggle-strobed nibble receiver assembling bytes into a FWFT FIFO; RX_PARITY_EN adds even-parity check.
// Latency: byte pushed on the low-nibble edge, visible on dout/dout_vld the next cycle.
// Backpressure: none upstream; bytes arriving to a full FIFO without a same-edge pop are dropped and flag ovf.
module nibble_rx
    import nibble_rx_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] nib_in,
    input  logic       nib_stb,
    input  logic       par_in,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       dout_vld,
    output logic       ovf,
    output logic       perr
);

    localparam int AW = $clog2(DEPTH);

    phase_t      ph_q;
    phase_t      ph_d;
    logic [3:0]  hi_q;
    logic [3:0]  hi_d;
    logic        stb_q;
    logic        tog;
    logic        push_req;
    logic [7:0]  byte_dat;
    logic        ovf_q;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    logic [AW:0] unused_count;

    assign tog      = nib_stb ^ stb_q;
    assign byte_dat = {hi_q, nib_in};

`ifdef RX_PARITY_EN
    logic perr_q;
    logic perr_set;
    logic par_bad;

    assign par_bad = parity_odd(byte_dat, par_in);
`else
    logic unused_par;

    assign unused_par = par_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q  <= PH_HI;
            hi_q  <= 4'h0;
            stb_q <= nib_stb;
        end else begin
            ph_q  <= ph_d;
            hi_q  <= hi_d;
            stb_q <= nib_stb;
        end
    end

    // Dropping en snaps back to the high-nibble phase so a partial byte is lost.
    always_comb begin
        ph_d     = ph_q;
        hi_d     = hi_q;
        push_req = 1'b0;
`ifdef RX_PARITY_EN
        perr_set = 1'b0;
`endif
        if (!en) begin
            ph_d = PH_HI;
        end else if (tog) begin
            case (ph_q)
                PH_HI: begin
                    hi_d = nib_in;
                    ph_d = PH_LO;
                end
                PH_LO: begin
                    ph_d = PH_HI;
`ifdef RX_PARITY_EN
                    if (par_bad) begin
                        perr_set = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
`else
                    push_req = 1'b1;
`endif
                end
                default: ph_d = PH_HI;
            endcase
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (byte_dat),
        .pop   (rd),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (push_req && fifo_full && !rd) begin
            ovf_q <= 1'b1;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (perr_set) begin
            perr_q <= 1'b1;
        end
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

    assign dout_vld = ~fifo_empty;
    assign dout     = dout_vld ? fifo_head : 8'h00;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_nibble_rx.sv
// Directed-vector bench for nibble_rx at DEPTH=4; parity checks follow RX_PARITY_EN.
module tb_nibble_rx;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] nib_in;
    logic       nib_stb;
    logic       par_in;
    logic       rd;
    logic [7:0] dout;
    logic       dout_vld;
    logic       ovf;
    logic       perr;

    int nvec;
    int nerr;

    nibble_rx #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .nib_in   (nib_in),
        .nib_stb  (nib_stb),
        .par_in   (par_in),
        .rd       (rd),
        .dout     (dout),
        .dout_vld (dout_vld),
        .ovf      (ovf),
        .perr     (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] n);
        nib_in  = n;
        nib_stb = ~nib_stb;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[7:4]);
        send_nib(b[3:0]);
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++;
        if ({dout_vld, dout, ovf, perr} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL reset_state: got vld=%b dout=%h ovf=%b perr=%b, expected 0/00/0/0",
                     dout_vld, dout, ovf, perr);
        end
    endtask

    task automatic test_basic();
        send_nib(4'hA);
        nvec++;
        if (dout_vld !== 1'b0) begin
            nerr++;
            $display("FAIL basic_half_byte: got vld=%b, expected 0", dout_vld);
        end
        send_nib(4'h5);
        nvec++;
        if ({dout_vld, dout} !== {1'b1, 8'hA5}) begin
            nerr++;
            $display("FAIL basic_byte: got vld=%b dout=%h, expected 1/a5", dout_vld, dout);
        end
        pop();
        nvec++;
        if ({dout_vld, dout} !== {1'b0, 8'h00}) begin
            nerr++;
            $display("FAIL basic_drain: got vld=%b dout=%h, expected 0/00", dout_vld, dout);
        end
        pop();
        nvec++;
        if ({dout_vld, ovf} !== 2'b00) begin
            nerr++;
            $display("FAIL basic_pop_empty: got vld=%b ovf=%b, expected 0/0", dout_vld, ovf);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            send_byte(exp_b);
        end
        nvec++;
        if (ovf !== 1'b0) begin
            nerr++;
            $display("FAIL ovf_at_full: got ovf=%b, expected 0", ovf);
        end
        send_byte(8'h05);
        nvec++;
        if (ovf !== 1'b1) begin
            nerr++;
            $display("FAIL ovf_set: got ovf=%b, expected 1", ovf);
        end
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            nvec++;
            if ({dout_vld, dout} !== {1'b1, exp_b}) begin
                nerr++;
                $display("FAIL ovf_drain[%0d]: got vld=%b dout=%h, expected 1/%h",
                         i, dout_vld, dout, exp_b);
            end
            pop();
        end
        nvec++;
        if ({dout_vld, dout, ovf} !== {1'b0, 8'h00, 1'b1}) begin
            nerr++;
            $display("FAIL ovf_sticky_empty: got vld=%b dout=%h ovf=%b, expected 0/00/1",
                     dout_vld, dout, ovf);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_b;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            send_byte(exp_b);
        end
        send_nib(4'h0);
        nib_in  = 4'h5;
        nib_stb = ~nib_stb;
        rd      = 1'b1;
        tick();
        rd      = 1'b0;
        nvec++;
        if (ovf !== 1'b0) begin
            nerr++;
            $display("FAIL full_pop_ovf: got ovf=%b, expected 0", ovf);
        end
        for (int i = 2; i <= 5; i++) begin
            exp_b = 8'(i);
            nvec++;
            if ({dout_vld, dout} !== {1'b1, exp_b}) begin
                nerr++;
                $display("FAIL full_pop_order[%0d]: got vld=%b dout=%h, expected 1/%h",
                         i, dout_vld, dout, exp_b);
            end
            pop();
        end
        nvec++;
        if (dout_vld !== 1'b0) begin
            nerr++;
            $display("FAIL full_pop_empty: got vld=%b, expected 0", dout_vld);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_byte(8'h10);
        send_nib(4'h2);
        nib_in  = 4'h0;
        nib_stb = ~nib_stb;
        rd      = 1'b1;
        tick();
        rd      = 1'b0;
        nvec++;
        if ({dout_vld, dout} !== {1'b1, 8'h20}) begin
            nerr++;
            $display("FAIL b2b_push_pop: got vld=%b dout=%h, expected 1/20", dout_vld, dout);
        end
        pop();
        nvec++;
        if (dout_vld !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_count: got vld=%b, expected 0", dout_vld);
        end
    endtask

    task automatic test_enable();
        do_reset();
        send_nib(4'hC);
        en = 1'b0;
        tick();
        en = 1'b1;
        send_nib(4'h3);
        send_nib(4'h7);
        nvec++;
        if ({dout_vld, dout} !== {1'b1, 8'h37}) begin
            nerr++;
            $display("FAIL en_partial_drop: got vld=%b dout=%h, expected 1/37", dout_vld, dout);
        end
        en = 1'b0;
        send_nib(4'h9);
        send_nib(4'h6);
        tick();
        nvec++;
        if ({dout_vld, dout} !== {1'b1, 8'h37}) begin
            nerr++;
            $display("FAIL en_low_ignore: got vld=%b dout=%h, expected 1/37", dout_vld, dout);
        end
        pop();
        en = 1'b1;
        tick();
        nvec++;
        if (dout_vld !== 1'b0) begin
            nerr++;
            $display("FAIL en_low_pop: got vld=%b, expected 0", dout_vld);
        end
    endtask

    task automatic test_parity();
        do_reset();
        par_in = 1'b1;
        send_byte(8'hA5);
`ifdef RX_PARITY_EN
        nvec++;
        if ({dout_vld, perr} !== 2'b01) begin
            nerr++;
            $display("FAIL parity_bad: got vld=%b perr=%b, expected 0/1", dout_vld, perr);
        end
        par_in = 1'b0;
        send_byte(8'hA5);
        nvec++;
        if ({dout_vld, dout, perr} !== {1'b1, 8'hA5, 1'b1}) begin
            nerr++;
            $display("FAIL parity_good: got vld=%b dout=%h perr=%b, expected 1/a5/1",
                     dout_vld, dout, perr);
        end
`else
        nvec++;
        if ({dout_vld, dout, perr} !== {1'b1, 8'hA5, 1'b0}) begin
            nerr++;
            $display("FAIL parity_ignored: got vld=%b dout=%h perr=%b, expected 1/a5/0",
                     dout_vld, dout, perr);
        end
`endif
        par_in = 1'b0;
        pop();
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'h11);
        send_byte(8'h22);
        send_nib(4'h3);
        rst     = 1'b1;
        nib_in  = 4'h4;
        nib_stb = ~nib_stb;
        tick();
        rst     = 1'b0;
        tick();
        nvec++;
        if ({dout_vld, dout, ovf} !== {1'b0, 8'h00, 1'b0}) begin
            nerr++;
            $display("FAIL rst_mid_clear: got vld=%b dout=%h ovf=%b, expected 0/00/0",
                     dout_vld, dout, ovf);
        end
        send_byte(8'h69);
        nvec++;
        if ({dout_vld, dout} !== {1'b1, 8'h69}) begin
            nerr++;
            $display("FAIL rst_mid_fresh: got vld=%b dout=%h, expected 1/69", dout_vld, dout);
        end
        pop();
        nvec++;
        if (dout_vld !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid_single: got vld=%b, expected 0", dout_vld);
        end
    endtask

    initial begin
        nvec    = 0;
        nerr    = 0;
        rst     = 1'b1;
        en      = 1'b1;
        nib_in  = 4'h0;
        nib_stb = 1'b0;
        par_in  = 1'b0;
        rd      = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_back_to_back();
        test_enable();
        test_parity();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
